// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN frame sequencer.
package cnn_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned IMG_PIXELS  = 784;
  localparam int unsigned DEC_W       = 4;
  localparam int unsigned NUM_CLASSES = 10;

  typedef enum logic [2:0] {
    LOAD,
    PRIME,
    STREAM,
    WAIT,
    RESULT
  } seq_state_e;

endpackage

// File: rtl/cnn_frame_buf.sv
// Single-frame pixel store: one write port, one synchronous read port (1-cycle latency).
module cnn_frame_buf
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_PIXELS,
  parameter int unsigned WIDTH = PIX_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Buffers one image from a byte stream, replays it into the CNN chip one byte per clock,
// then captures the chip's decision (or a timeout) and hands it downstream.
module cnn_frame_sequencer #(
  parameter int unsigned PIX_W          = cnn_pkg::PIX_W,
  parameter int unsigned IMG_PIXELS     = cnn_pkg::IMG_PIXELS,
  parameter int unsigned DEC_W          = cnn_pkg::DEC_W,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic             chip_rst_n,
  output logic [PIX_W-1:0] chip_data,
  input  logic [DEC_W-1:0] chip_decision,
  input  logic             chip_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DEC_W-1:0] res_decision,
  output logic             res_timeout,
  output logic             frame_err,
  output logic             busy
);

  import cnn_pkg::*;

  localparam int unsigned IDX_W = $clog2(IMG_PIXELS);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_PIXELS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             rd_done_q;
  logic             drive_q;
  logic [PIX_W-1:0] rd_data;
  logic             beat;
  logic             rd_en;

  assign beat  = s_valid & s_ready;
  assign rd_en = (state_q == PRIME) | ((state_q == STREAM) & ~rd_done_q);

  // The RAM output register is the pixel pipeline stage; drive_q only gates it to zero
  // outside the streaming window so buf[k] lands on the chip k+1 cycles after PRIME.
  assign chip_data = drive_q ? rd_data : '0;

  cnn_frame_buf #(
    .DEPTH (IMG_PIXELS),
    .WIDTH (PIX_W)
  ) u_frame_buf (
    .clk     (clk),
    .wr_en   (beat),
    .wr_addr (wr_idx_q),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_idx_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      s_ready      <= 1'b0;
      chip_rst_n   <= 1'b0;
      drive_q      <= 1'b0;
      res_valid    <= 1'b0;
      res_timeout  <= 1'b0;
      res_decision <= '0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      rd_done_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      frame_err <= 1'b0;
      unique case (state_q)
        LOAD: begin
          s_ready <= 1'b1;
          if (beat) begin
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_q <= '0;
              if (s_last) begin
                state_q    <= PRIME;
                s_ready    <= 1'b0;
                busy       <= 1'b1;
                chip_rst_n <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (s_last) begin
              wr_idx_q  <= '0;
              frame_err <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
          end
        end
        PRIME: begin
          rd_idx_q <= IDX_W'(1);
          drive_q  <= 1'b1;
          state_q  <= STREAM;
        end
        STREAM: begin
          if (rd_done_q) begin
            // rd_data currently holds the final pixel; this is its only cycle on the bus.
            drive_q   <= 1'b0;
            rd_done_q <= 1'b0;
            rd_idx_q  <= '0;
            tmo_cnt_q <= '0;
            state_q   <= WAIT;
          end else if (rd_idx_q == LAST_IDX) begin
            rd_done_q <= 1'b1;
          end else begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
          end
        end
        WAIT: begin
          if (chip_valid) begin
            res_decision <= chip_decision;
            res_timeout  <= 1'b0;
            res_valid    <= 1'b1;
            chip_rst_n   <= 1'b0;
            state_q      <= RESULT;
          end else if (tmo_cnt_q == TMO_LAST) begin
            res_decision <= '0;
            res_timeout  <= 1'b1;
            res_valid    <= 1'b1;
            chip_rst_n   <= 1'b0;
            tmo_cnt_q    <= tmo_cnt_q + TMO_W'(1);
            state_q      <= RESULT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            state_q   <= LOAD;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: directed frames, a behavioural chip model,
// and a monitor that pops expected pixels/results as the DUT presents them.
module tb_cnn_frame_sequencer;

  localparam int NPIX = 784;
  localparam int TMO  = 8192;

  typedef struct {
    logic [3:0] dec;
    logic       to;
    int         lat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       chip_rst_n;
  logic [7:0] chip_data;
  logic [3:0] chip_decision;
  logic       chip_valid;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_decision;
  logic       res_timeout;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .PIX_W          (8),
    .IMG_PIXELS     (NPIX),
    .DEC_W          (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .chip_rst_n    (chip_rst_n),
    .chip_data     (chip_data),
    .chip_decision (chip_decision),
    .chip_valid    (chip_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_decision  (res_decision),
    .res_timeout   (res_timeout),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];
  int         mon_pos = -1;
  int         prime_cnt = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  int         wait_entry = 0;
  int         chip_resp_at = -1;
  logic [3:0] chip_dec = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not as required at t=%0t", name, $time);
  endtask

  function automatic logic [7:0] pix(input int pat, input int k);
    case (pat)
      0:       return 8'(k);
      1:       return 8'(k * 3 + 1);
      2:       return 8'(255 - k);
      default: return 8'(k * 7 + 3);
    endcase
  endfunction

  // Chip model: counts cycles from reset release (PRIME = 0, WAIT entry = NPIX+1),
  // answers chip_resp_at cycles into WAIT, and fires a stray pulse mid-stream.
  initial begin : chip_model
    int ccnt;
    ccnt = -1;
    chip_valid = 1'b0;
    chip_decision = 4'd0;
    forever begin
      @(negedge clk);
      if (!chip_rst_n) ccnt = -1;
      else ccnt++;
      chip_valid = (ccnt == 100) ||
                   (chip_resp_at >= 0 && ccnt == NPIX + 1 + chip_resp_at);
      chip_decision = (ccnt == 100) ? 4'd7 : chip_dec;
    end
  end

  initial begin : monitor
    logic [7:0] eb;
    res_t       held;
    bit         rv_prev;
    bit         popped;
    rv_prev = 1'b0;
    popped  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        mon_pos = -1;
        rv_prev = 1'b0;
        popped  = 1'b0;
      end else begin
        if (frame_err) err_seen++;
        if (!chip_rst_n) begin
          mon_pos = -1;
        end else if (mon_pos < 0) begin
          mon_pos = 0;
          prime_cnt++;
          check("prime_outputs", {chip_data, busy, s_ready}, {8'h00, 1'b1, 1'b0});
        end else begin
          mon_pos++;
          if (mon_pos <= NPIX) begin
            if (exp_bytes.size() == 0) fail_now("stream_extra_byte");
            else begin
              eb = exp_bytes.pop_front();
              check("stream_byte", {s_ready, chip_data}, {1'b0, eb});
            end
          end else if (mon_pos == NPIX + 1) begin
            wait_entry = cyc;
            check("wait_data_zero", chip_data, 8'h00);
          end
        end
        if (popped) begin
          check("res_drop", {res_valid, s_ready}, 2'b01);
          popped = 1'b0;
        end
        if (res_valid) begin
          if (!rv_prev) begin
            if (exp_res.size() == 0) begin
              fail_now("res_unexpected");
              held = '{dec: res_decision, to: res_timeout, lat: 0};
            end else begin
              held = exp_res[0];
              check("res_decision", res_decision, held.dec);
              check("res_timeout", res_timeout, held.to);
              check("res_latency", cyc - wait_entry, held.lat);
            end
          end else begin
            check("res_stable", {res_decision, res_timeout}, {held.dec, held.to});
          end
          if (res_ready) begin
            popped = 1'b1;
            if (exp_res.size() > 0) held = exp_res.pop_front();
          end
        end
        rv_prev = res_valid;
      end
    end
  end

  task automatic send_frame(input int pat, input int n, input int last_at, input bit bp);
    bit good;
    int wt;
    good = (n == NPIX) && (last_at == NPIX - 1);
    if (good) for (int k = 0; k < NPIX; k++) exp_bytes.push_back(pix(pat, k));
    for (int k = 0; k < n; k++) begin
      if (bp && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = pix(pat, k);
      s_last  = (k == last_at);
      wt = 0;
      while (!s_ready && wt < 200) begin
        @(negedge clk);
        wt++;
      end
      if (!s_ready) begin
        fail_now("s_ready_wait");
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("rst_n_after_last", chip_rst_n, good);
    if (!good) check("s_ready_after_err", s_ready, 1'b1);
  endtask

  task automatic get_result(input int hold, input int budget);
    int n;
    n = 0;
    res_ready = (hold < 0);
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      fail_now("res_wait");
      res_ready = 1'b0;
      return;
    end
    if (hold >= 0) begin
      repeat (hold) @(negedge clk);
      res_ready = 1'b1;
    end
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int pc;
    int n;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_s_ready", s_ready, 1'b0);
    check("reset_chip_rst_n", chip_rst_n, 1'b0);
    check("reset_chip_data", chip_data, 8'h00);
    check("reset_res", {res_valid, res_timeout, res_decision}, 6'h00);
    check("reset_err_busy", {frame_err, busy}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1'b1);

    // Good frame, chip answers 50 cycles into WAIT, consumer stalls 10 cycles
    chip_resp_at = 50;
    chip_dec = 4'd2;
    exp_res.push_back('{dec: 4'd2, to: 1'b0, lat: 51});
    send_frame(0, NPIX, NPIX - 1, 1'b0);
    get_result(10, 2000);

    // Early s_last
    err_exp++;
    send_frame(1, 101, 100, 1'b0);
    @(negedge clk);
    check("frame_err_early_last", err_seen, err_exp);

    // Next good frame, immediate chip answer, res_ready already high on entry
    chip_resp_at = 0;
    chip_dec = 4'd9;
    exp_res.push_back('{dec: 4'd9, to: 1'b0, lat: 1});
    send_frame(1, NPIX, NPIX - 1, 1'b0);
    get_result(-1, 2000);

    // Missing s_last
    pc = prime_cnt;
    err_exp++;
    send_frame(2, NPIX, -1, 1'b0);
    @(negedge clk);
    check("frame_err_missing_last", err_seen, err_exp);
    repeat (5) @(negedge clk);
    check("no_stream_on_err", prime_cnt, pc);

    // Chip never answers
    chip_resp_at = -1;
    exp_res.push_back('{dec: 4'd0, to: 1'b1, lat: TMO});
    send_frame(2, NPIX, NPIX - 1, 1'b0);
    get_result(2, TMO + 2000);

    // Reset while rd_idx = 400
    chip_resp_at = 30;
    chip_dec = 4'd3;
    send_frame(0, NPIX, NPIX - 1, 1'b0);
    n = 0;
    while (mon_pos != 399 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (mon_pos != 399) fail_now("reach_rd_idx_400");
    rst = 1'b1;
    #1;
    check("midrst_chip_rst_n", chip_rst_n, 1'b0);
    check("midrst_chip_data", chip_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_s_ready", s_ready, 1'b0);
    exp_bytes.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_res.push_back('{dec: 4'd3, to: 1'b0, lat: 31});
    send_frame(0, NPIX, NPIX - 1, 1'b0);
    get_result(0, 2000);

    // Upstream backpressure
    chip_resp_at = 20;
    chip_dec = 4'd5;
    exp_res.push_back('{dec: 4'd5, to: 1'b0, lat: 21});
    send_frame(3, NPIX, NPIX - 1, 1'b1);
    get_result(3, 2000);

    repeat (3) @(negedge clk);
    check("exp_bytes_left", exp_bytes.size(), 0);
    check("exp_res_left", exp_res.size(), 0);
    check("frame_err_count", err_seen, err_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Synthesizable replacement for the bench-side pixel driver in front of the CNN `chip`. It accepts one 28x28 MNIST image (784 bytes) from an upstream valid/ready byte stream and buffers it. It then holds `chip` in reset, releases it and streams the buffer into `chip.data_in` at one byte per clock. Finally it captures `decision` when `valid_out_6` fires and presents the result downstream with a valid/ready handshake.

Parameters:
- PIX_W, 8, pixel width in bits; matches `chip` DATA_BITS.
- IMG_PIXELS, 784, bytes per frame.
- DEC_W, 4, decision width.
- TIMEOUT_CYCLES, 8192, maximum cycles to wait for `chip_valid` after the last pixel.

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- s_valid, in, 1, upstream byte valid.
- s_ready, out, 1, upstream byte ready.
- s_data, in, PIX_W, upstream pixel byte.
- s_last, in, 1, marks the final byte of a frame.
- chip_rst_n, out, 1, active-low reset driven to `chip`.
- chip_data, out, PIX_W, drives `chip.data_in`.
- chip_decision, in, DEC_W, from `chip.decision`.
- chip_valid, in, 1, from `chip.valid_out_6`.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result accepted.
- res_decision, out, DEC_W, captured class 0..9.
- res_timeout, out, 1, qualifies res_valid: the chip never answered.
- frame_err, out, 1, one-cycle pulse on a malformed input frame.
- busy, out, 1, high in every state except LOAD.

Behaviour:
- Reset values:
  - state = LOAD; s_ready = 0 during reset, 1 after.
  - chip_rst_n = 0; chip_data = 0.
  - res_valid = res_timeout = frame_err = busy = 0; res_decision = 0.
  - Index and timeout counters = 0.
- Counters: wr_idx and rd_idx are $clog2(IMG_PIXELS) bits (10 at default). Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
- Reset asserted mid-operation: everything returns to the reset values immediately, the partial frame is discarded and chip_rst_n goes 0. Buffer contents are don't-care.
- LOAD:
  - s_ready = 1, chip_rst_n = 0.
  - Each beat (s_valid & s_ready) writes s_data to buf[wr_idx] and increments wr_idx.
  - Early last: s_last on a beat with wr_idx < IMG_PIXELS-1 → frame_err pulse, wr_idx := 0, stay in LOAD.
  - Missing last: a beat at wr_idx = IMG_PIXELS-1 without s_last → frame_err pulse, wr_idx := 0, stay in LOAD.
  - Good frame: a beat at wr_idx = IMG_PIXELS-1 with s_last → PRIME, wr_idx := 0.
- PRIME (1 cycle):
  - s_ready = 0, chip_rst_n goes 1 at this edge.
  - Issue the synchronous read of buf[0]; rd_idx := 1.
- STREAM:
  - Each cycle chip_data <= read data, the next address is issued, and rd_idx increments.
  - buf[k] appears on chip_data exactly k+1 cycles after PRIME entry, with contiguous bytes and no gaps.
  - After buf[IMG_PIXELS-1] has been driven for one cycle, chip_data := 0 → WAIT, timeout counter := 0.
- WAIT:
  - chip_data holds 0; the timeout counter increments each cycle.
  - chip_valid = 1 → res_decision := chip_decision, res_timeout := 0 → RESULT.
  - Counter reaches TIMEOUT_CYCLES first → res_decision := 0, res_timeout := 1 → RESULT.
  - chip_valid and the timeout in the same cycle: chip_valid wins.
- RESULT:
  - res_valid = 1 with res_decision and res_timeout stable; chip_rst_n = 0.
  - Hold until res_ready; on acceptance res_valid drops next cycle → LOAD.
  - res_ready high on the entry cycle still costs one cycle of res_valid.
- chip_valid outside WAIT is ignored.
- s_ready = 0 outside LOAD. A new frame is not accepted until the previous result is consumed (no overlap).
- Latency: last input beat to first chip byte = 2 cycles. Full frame through the chip = IMG_PIXELS + 1 cycles of PRIME/STREAM.

Decomposition:
- Package cnn_pkg: IMG_PIXELS, PIX_W, DEC_W, NUM_CLASSES = 10, state enum {LOAD, PRIME, STREAM, WAIT, RESULT}.
- Sub-module cnn_frame_buf: IMG_PIXELS x PIX_W simple dual-port RAM, one write port and one synchronous read port with 1-cycle latency.
- FSM, counters and handshakes stay in the top module.

Test Plan:
- Good frame: send bytes k mod 256 for k = 0..783, s_last on byte 783 → chip_rst_n rises 1 cycle after the last beat; chip_data sequence 0x00, 0x01, …, 0x0F (byte 783) on consecutive cycles, then 0x00; s_ready = 0 throughout.
- Result path: model `chip` raises chip_valid 50 cycles into WAIT with decision = 4'd2, res_ready held 0 for 10 cycles → res_valid = 1 with res_decision = 2 and res_timeout = 0, stable for 10 cycles; drops the cycle after res_ready; s_ready = 1 next.
- Malformed frames: s_last on byte 100 → one-cycle frame_err pulse, s_ready stays 1, next full 784-byte frame streams normally. Then 784 bytes with no s_last → frame_err pulse, no STREAM.
- Timeout: chip_valid never asserted → exactly TIMEOUT_CYCLES = 8192 cycles after WAIT entry, res_valid = 1, res_timeout = 1, res_decision = 0.
- Reset mid-stream: assert rst at rd_idx = 400 → chip_rst_n = 0, chip_data = 0, busy = 0 immediately; the next full frame streams from byte 0.
- Backpressure: toggle s_valid 50% random across a frame → buffer contents and chip_data order are unchanged, with contiguous streaming.
